// File: rtl/galaga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : galaga_pkg
// Description : Shared definitions for the Galaga shot controller: lane
//               encoding constants, shot FSM state encoding and a helper that
//               turns three one-hot lane flags into a lane code.
// Revision    : 1.0 - initial release
// ============================================================================
package galaga_pkg;

    // Lane codes as seen on SHOT_LANE
    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_L    = 2'b01;
    localparam logic [1:0] LANE_C    = 2'b10;
    localparam logic [1:0] LANE_R    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FLY  = 3'd1,
        ST_HIT  = 3'd2,
        ST_MISS = 3'd3,
        ST_COOL = 3'd4,
        ST_WIN  = 3'd5
    } shot_state_e;

    // Anything that is not exactly one-hot maps to LANE_NONE, so callers
    // can use a single compare for both validity and lane identity.
    function automatic logic [1:0] lane_of(input logic l, input logic c, input logic r);
        logic [1:0] lane;
        case ({l, c, r})
            3'b100:  lane = LANE_L;
            3'b010:  lane = LANE_C;
            3'b001:  lane = LANE_R;
            default: lane = LANE_NONE;
        endcase
        return lane;
    endfunction

endpackage : galaga_pkg
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ============================================================================
// Module      : edge_det
// Description : Rising-edge detector for the raw fire button.
//               P is high in the cycle where D is 1 and the registered D is 0.
// Ports       : CLK - clock
//               RST - synchronous active-high reset
//               D   - level input
//               P   - rising-edge pulse (combinational, one cycle per edge)
// Revision    : 1.0 - initial release
// ============================================================================
module edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic P
);

    logic d_q;
    // arm_q stays low after reset until D has been seen low once, so a level
    // held high straight through reset release does not look like a new edge.
    logic arm_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            d_q   <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            d_q   <= D;
            arm_q <= arm_q | ~D;
        end
    end

    assign P = D & ~d_q & arm_q;

endmodule : edge_det
`default_nettype wire

// File: rtl/shot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shot_ctrl
// Description : Projectile controller. A fire edge with a valid shooter lane
//               launches a shot that climbs ROWS rows, one every STEP_DIV
//               cycles, and is then scored against the target lane. Each
//               resolved shot is followed by COOL_CYC cooldown cycles; the
//               game ends when SCORE reaches MAX_SCORE.
// Ports       : CLK, RST          - clock, synchronous active-high reset
//               FIRE              - raw fire button (level)
//               L, C, R           - shooter lane, one-hot
//               L2, C2, R2        - target lane, one-hot
//               SHOT_ACTIVE       - projectile in flight
//               SHOT_LANE [1:0]   - latched lane while flying, else 00
//               SHOT_ROW  [2:0]   - current projectile row
//               HIT, MISS         - one-cycle result pulses
//               SCORE     [3:0]   - hit count
//               WIN               - game over
// Revision    : 1.0 - initial release
// ============================================================================
module shot_ctrl
    import galaga_pkg::*;
#(
    parameter int unsigned STEP_DIV  = 4,
    parameter int unsigned ROWS      = 6,
    parameter int unsigned COOL_CYC  = 8,
    parameter int unsigned MAX_SCORE = 9
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FIRE,
    input  logic       L,
    input  logic       C,
    input  logic       R,
    input  logic       L2,
    input  logic       C2,
    input  logic       R2,
    output logic       SHOT_ACTIVE,
    output logic [1:0] SHOT_LANE,
    output logic [2:0] SHOT_ROW,
    output logic       HIT,
    output logic       MISS,
    output logic [3:0] SCORE,
    output logic       WIN
);

    localparam logic [7:0] C_DIV_LAST  = 8'(STEP_DIV - 1);
    localparam logic [7:0] C_COOL_LAST = 8'(COOL_CYC - 1);
    localparam logic [2:0] C_ROW_LAST  = 3'(ROWS - 1);
    localparam logic [3:0] C_MAX       = 4'(MAX_SCORE);

    shot_state_e state_q, state_d;
    logic [1:0]  lane_q,  lane_d;
    logic [2:0]  row_q,   row_d;
    logic [7:0]  div_q,   div_d;
    logic [7:0]  cool_q,  cool_d;
    logic [3:0]  score_q, score_d;

    logic       w_fire_p;
    logic [1:0] w_shoot_lane;
    logic [1:0] w_tgt_lane;
    logic [3:0] w_score_inc;

    edge_det u_fire_edge (
        .CLK (CLK),
        .RST (RST),
        .D   (FIRE),
        .P   (w_fire_p)
    );

    assign w_shoot_lane = lane_of(L, C, R);
    assign w_tgt_lane   = lane_of(L2, C2, R2);
    assign w_score_inc  = (score_q < C_MAX) ? score_q + 4'd1 : score_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lane_q  <= LANE_NONE;
            row_q   <= 3'd0;
            div_q   <= 8'd0;
            cool_q  <= 8'd0;
            score_q <= 4'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            row_q   <= row_d;
            div_q   <= div_d;
            cool_q  <= cool_d;
            score_q <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        row_d   = row_q;
        div_d   = div_q;
        cool_d  = cool_q;
        score_d = score_q;

        case (state_q)
            ST_IDLE: begin
                // Fire edges in any other state are simply dropped here.
                if (w_fire_p && (w_shoot_lane != LANE_NONE)) begin
                    state_d = ST_FLY;
                    lane_d  = w_shoot_lane;
                    row_d   = 3'd0;
                    div_d   = 8'd0;
                end
            end
            ST_FLY: begin
                if (div_q == C_DIV_LAST) begin
                    div_d = 8'd0;
                    if (row_q == C_ROW_LAST) begin
                        // lane_q is never NONE here, so a non-one-hot
                        // target (NONE) can never match and scores a miss.
                        state_d = (w_tgt_lane == lane_q) ? ST_HIT : ST_MISS;
                        row_d   = 3'd0;
                        lane_d  = LANE_NONE;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_HIT: begin
                score_d = w_score_inc;
                cool_d  = 8'd0;
                state_d = (w_score_inc == C_MAX) ? ST_WIN : ST_COOL;
            end
            ST_MISS: begin
                cool_d  = 8'd0;
                state_d = ST_COOL;
            end
            ST_COOL: begin
                if (cool_q == C_COOL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cool_d = cool_q + 8'd1;
                end
            end
            ST_WIN: begin
                state_d = ST_WIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign SHOT_ACTIVE = (state_q == ST_FLY);
    assign SHOT_LANE   = (state_q == ST_FLY) ? lane_q : LANE_NONE;
    assign SHOT_ROW    = row_q;
    assign HIT         = (state_q == ST_HIT);
    assign MISS        = (state_q == ST_MISS);
    assign SCORE       = score_q;
    assign WIN         = (state_q == ST_WIN);

endmodule : shot_ctrl
`default_nettype wire

// File: tb/tb_shot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shot_ctrl
// Description : Self-checking bench for shot_ctrl. A transaction-level model
//               predicts each shot's flight window, result pulse and score
//               from the game rules; result pulses go through a queue that a
//               separate monitor drains, level outputs are checked against
//               per-cycle expectation tables filled by the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shot_ctrl;

    localparam int STEP_DIV  = 4;
    localparam int ROWS      = 6;
    localparam int COOL_CYC  = 8;
    localparam int MAX_SCORE = 2;
    localparam int NFLY      = ROWS * STEP_DIV;
    localparam int NCYC      = 4000;
    localparam int INF       = 1 << 30;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       FIRE = 1'b0;
    logic       L = 1'b0, C = 1'b0, R = 1'b0;
    logic       L2 = 1'b0, C2 = 1'b0, R2 = 1'b0;
    logic       SHOT_ACTIVE;
    logic [1:0] SHOT_LANE;
    logic [2:0] SHOT_ROW;
    logic       HIT, MISS;
    logic [3:0] SCORE;
    logic       WIN;

    always #5 CLK = ~CLK;

    shot_ctrl #(
        .STEP_DIV  (STEP_DIV),
        .ROWS      (ROWS),
        .COOL_CYC  (COOL_CYC),
        .MAX_SCORE (MAX_SCORE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .FIRE        (FIRE),
        .L           (L),
        .C           (C),
        .R           (R),
        .L2          (L2),
        .C2          (C2),
        .R2          (R2),
        .SHOT_ACTIVE (SHOT_ACTIVE),
        .SHOT_LANE   (SHOT_LANE),
        .SHOT_ROW    (SHOT_ROW),
        .HIT         (HIT),
        .MISS        (MISS),
        .SCORE       (SCORE),
        .WIN         (WIN)
    );

    typedef struct {
        bit hit;
        int cyc;
    } pulse_t;

    pulse_t exp_q[$];
    int exp_act   [NCYC];
    int exp_lane  [NCYC];
    int exp_row   [NCYC];
    int exp_score [NCYC];
    int exp_win   [NCYC];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Game-level model state
    int idle_from = 0;
    int eval_cyc  = -1;
    int fly_lane  = 0;
    int score     = 0;
    bit armed     = 1'b0;
    bit prev_fire = 1'b0;

    function automatic int lane_code(input logic l, input logic c, input logic r);
        if ({l, c, r} == 3'b100) return 1;
        if ({l, c, r} == 3'b010) return 2;
        if ({l, c, r} == 3'b001) return 3;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Predicts the consequences of the inputs applied in the current cycle.
    task automatic model_eval();
        int  k;
        bit  fire_edge;
        bit  hit;
        k = cyc;
        if (RST) begin
            for (int c = k + 1; c < NCYC; c++) begin
                exp_act[c] = 0; exp_lane[c] = 0; exp_row[c] = 0;
                exp_score[c] = 0; exp_win[c] = 0;
            end
            idle_from = k + 1;
            eval_cyc  = -1;
            score     = 0;
            armed     = 1'b0;
            prev_fire = 1'b0;
            return;
        end
        fire_edge = FIRE && !prev_fire && armed;
        if (k == eval_cyc) begin
            hit = (lane_code(L2, C2, R2) == fly_lane);
            exp_q.push_back('{hit: hit, cyc: k + 1});
            eval_cyc = -1;
            if (hit) begin
                if (score < MAX_SCORE) score++;
                for (int c = k + 2; c < NCYC; c++) exp_score[c] = score;
            end
            if (hit && score == MAX_SCORE) begin
                for (int c = k + 2; c < NCYC; c++) exp_win[c] = 1;
                idle_from = INF;
            end else begin
                idle_from = k + 2 + COOL_CYC;
            end
        end else if (k >= idle_from && fire_edge && lane_code(L, C, R) != 0) begin
            fly_lane  = lane_code(L, C, R);
            eval_cyc  = k + NFLY;
            idle_from = INF;
            for (int c = k + 1; c <= k + NFLY && c < NCYC; c++) begin
                exp_act[c]  = 1;
                exp_lane[c] = fly_lane;
                exp_row[c]  = (c - k - 1) / STEP_DIV;
            end
        end
        if (!FIRE) armed = 1'b1;
        prev_fire = FIRE;
    endtask

    task automatic step();
        model_eval();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic ship(input logic l, input logic c, input logic r);
        L = l; C = c; R = r;
    endtask

    task automatic tgt(input logic l, input logic c, input logic r);
        L2 = l; C2 = c; R2 = r;
    endtask

    // Monitor: level outputs every cycle, result pulses against the queue
    initial begin
        forever begin
            @(negedge CLK);
            if (cyc >= 1 && cyc < NCYC) begin
                chk("shot_active", 32'(SHOT_ACTIVE), 32'(exp_act[cyc]));
                chk("shot_lane",   32'(SHOT_LANE),   32'(exp_lane[cyc]));
                chk("shot_row",    32'(SHOT_ROW),    32'(exp_row[cyc]));
                chk("score",       32'(SCORE),       32'(exp_score[cyc]));
                chk("win",         32'(WIN),         32'(exp_win[cyc]));
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL missing_pulse @cycle %0d: got none, expected %s at cycle %0d",
                             cyc, exp_q[0].hit ? "HIT" : "MISS", exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                if (HIT || MISS) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_pulse @cycle %0d: got HIT=%0b MISS=%0b, expected none",
                                 cyc, HIT, MISS);
                    end else begin
                        pulse_t e;
                        e = exp_q.pop_front();
                        chk("hit_pulse",  32'(HIT),  32'(e.hit));
                        chk("miss_pulse", 32'(MISS), 32'(!e.hit));
                    end
                end
            end
        end
    end

    initial begin
        int sel;
        // FIRE held high through reset and release: no shot
        RST = 1'b1; FIRE = 1'b1; ship(0, 1, 0); tgt(0, 1, 0);
        run(3);
        RST = 1'b0;
        run(6);
        // Centre shot on centre target, FIRE held long: one hit only
        FIRE = 1'b0; run(3);
        FIRE = 1'b1; run(50);
        FIRE = 1'b0; run(5);
        // Left shot on right target; shooter moves and re-fires mid-flight,
        // then fires again during cooldown
        ship(1, 0, 0); tgt(0, 0, 1);
        FIRE = 1'b1; run(2);
        FIRE = 1'b0; run(5);
        ship(0, 0, 1);
        FIRE = 1'b1; run(2);
        FIRE = 1'b0; run(20);
        FIRE = 1'b1; run(1);
        FIRE = 1'b0; run(15);
        // Invalid shooter lane
        ship(1, 1, 0);
        FIRE = 1'b1; run(2);
        FIRE = 1'b0; run(3);
        // Reset in the middle of a flight (row 3)
        ship(1, 0, 0); tgt(1, 0, 0);
        FIRE = 1'b1; run(1);
        FIRE = 1'b0; run(1 + 3 * STEP_DIV);
        RST = 1'b1; run(1);
        RST = 1'b0; run(30);
        // Two hits from zero reach MAX_SCORE; WIN ignores fire; reset clears
        RST = 1'b1; run(1);
        RST = 1'b0; ship(0, 1, 0); tgt(0, 1, 0);
        FIRE = 1'b1; run(1);
        FIRE = 1'b0; run(40);
        FIRE = 1'b1; run(1);
        FIRE = 1'b0; run(40);
        FIRE = 1'b1; run(2);
        FIRE = 1'b0; run(20);
        RST = 1'b1; run(1);
        RST = 1'b0; run(3);
        // Randomized play
        for (int i = 0; i < 2500 && cyc < NCYC - 200; i++) begin
            RST = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) FIRE = ~FIRE;
            if ($urandom_range(0, 7) == 0) begin
                sel = $urandom_range(0, 4);
                case (sel)
                    0: ship(1, 0, 0);
                    1: ship(0, 1, 0);
                    2: ship(0, 0, 1);
                    3: ship(0, 0, 0);
                    default: ship(1, 1, 0);
                endcase
            end
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, 4);
                case (sel)
                    0: tgt(1, 0, 0);
                    1: tgt(0, 1, 0);
                    2: tgt(0, 0, 1);
                    default: begin
                        L2 = 1'($urandom_range(0, 1));
                        C2 = 1'($urandom_range(0, 1));
                        R2 = 1'($urandom_range(0, 1));
                    end
                endcase
            end
            run(1);
        end
        RST = 1'b0; FIRE = 1'b0;
        run(NFLY + COOL_CYC + 10);
        chk("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_shot_ctrl
`default_nettype wire

// File: doc/shot_ctrl.md
SHOT_CTRL -- requirements
Module: shot_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4: clock cycles per projectile row advance, legal range 1..255.
REQ-002 SHALL have parameter ROWS, default 6: rows travelled before hit evaluation, legal range 2..7.
REQ-003 SHALL have parameter COOL_CYC, default 8: cooldown cycles after each shot resolves, legal range 1..255.
REQ-004 SHALL have parameter MAX_SCORE, default 9: score reaching this value ends the game, legal range 1..15.
REQ-005 SHALL have one clock; reset is synchronous and active-high; ports are named CLK and RST.
REQ-006 CLK  input  1  system clock, all state changes on the rising edge.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 FIRE  input  1  raw fire button, level.
REQ-009 L, C, R  input  1 each  shooter ship lane, one-hot, from the ship-1 movement FSM.
REQ-010 L2, C2, R2  input  1 each  target ship lane, one-hot, from the ship-2 movement FSM.
REQ-011 SHOT_ACTIVE  output  1  projectile in flight.
REQ-012 SHOT_LANE  output  2  latched lane: 00 none, 01 L, 10 C, 11 R.
REQ-013 SHOT_ROW  output  3  current projectile row, 0..ROWS-1.
REQ-014 HIT  output  1  one-cycle pulse on a successful hit.
REQ-015 MISS  output  1  one-cycle pulse on a miss.
REQ-016 SCORE  output  4  hit count.
REQ-017 WIN  output  1  game over, SCORE reached MAX_SCORE.

Function
REQ-018 SHALL implement states IDLE, FLY, HIT, MISS, COOL, and WIN.
REQ-019 SHALL detect a FIRE rising edge when the registered FIRE is 0 and the current FIRE is 1; holding FIRE high SHALL NOT retrigger.
REQ-020 In IDLE, a FIRE edge with exactly one of L/C/R high SHALL latch SHOT_LANE and enter FLY on the next edge, with SHOT_ROW=0 and SHOT_ACTIVE=1.
REQ-021 In IDLE, a FIRE edge with L/C/R not one-hot SHALL be ignored and the block SHALL stay in IDLE.
REQ-022 A FIRE edge in any state other than IDLE SHALL be discarded and SHALL NOT be queued.
REQ-023 In FLY, SHOT_ROW SHALL increment once every STEP_DIV cycles; the divider SHALL clear on entry to FLY.
REQ-024 When the divider expires with SHOT_ROW=ROWS-1, the block SHALL compare SHOT_LANE against L2/C2/R2 sampled in that same cycle; a match SHALL go to HIT, otherwise to MISS.
REQ-025 Total flight time SHALL be ROWS*STEP_DIV cycles from entry to FLY until HIT or MISS.
REQ-026 A target that is not one-hot at evaluation SHALL count as a miss.
REQ-027 HIT and MISS SHALL each last exactly one cycle, with the corresponding pulse high and SHOT_ACTIVE=0.
REQ-028 In HIT, SCORE SHALL increment, saturating at MAX_SCORE.
REQ-029 If the new SCORE equals MAX_SCORE, the next state SHALL be WIN; otherwise COOL.
REQ-030 MISS SHALL always go to COOL.
REQ-031 COOL SHALL last COOL_CYC cycles and then return to IDLE.
REQ-032 SHOT_LANE SHALL read 00 in every state except FLY.
REQ-033 WIN SHALL be terminal until RST, with WIN=1, SCORE held, and FIRE ignored.
REQ-034 Lane changes of the shooter during FLY SHALL NOT affect SHOT_LANE.

Reset
REQ-035 RST=1 at a rising edge SHALL force IDLE, SHOT_ACTIVE=0, SHOT_LANE=00, SHOT_ROW=0, HIT=0, MISS=0, SCORE=0, WIN=0, clear the divider and cooldown counters, and clear the registered FIRE.
REQ-036 RST SHALL take priority over all events, including mid-flight and in WIN.
REQ-037 A FIRE held high through reset release SHALL NOT fire; a new rising edge is required.

Structure
REQ-038 The lane encoding constants (NONE, L, C, R) and the state encoding SHALL reside in the shared package galaga_pkg.
REQ-039 FIRE edge detection SHALL be a sub-module edge_det (inputs CLK, RST, D; output pulse P).
REQ-040 The FSM, row/divider counter, cooldown counter, and score register SHALL reside in shot_ctrl.

Verification
REQ-041 Defaults. C=1 and FIRE edge at cycle 10 with target C2=1 -> FLY at cycle 11, SHOT_LANE=10, rows 0..5, HIT pulse at cycle 35, SCORE=1, IDLE at cycle 44.
REQ-042 L=1 and FIRE with target R2=1 -> MISS pulse after 24 flight cycles, SCORE unchanged at 0, then 8 COOL cycles.
REQ-043 FIRE held high for 50 cycles -> exactly one shot; a second FIRE edge during FLY/COOL -> no second shot.
REQ-044 MAX_SCORE=2 with two hits -> SCORE=2 and WIN=1; a subsequent FIRE edge -> no response; RST -> all outputs 0.
REQ-045 RST asserted at SHOT_ROW=3 -> next cycle IDLE, SHOT_ACTIVE=0, SHOT_ROW=0, no HIT/MISS pulse.
REQ-046 L=C=1 (invalid) with a FIRE edge -> stays IDLE; shooter moves L->R mid-flight -> SHOT_LANE stays 01.
